// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding, master
// indices, default bus widths and the debug view of the arbiter FSM.
package bus_arb_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic M_HOST = 1'b0;
    localparam logic M_DMAC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

    typedef struct packed {
        arb_state_e state;
        logic       last_owner;
    } arb_dbg_t;

endpackage

// File: rtl/bus_arb_watchdog.sv
// Hold-time watchdog: counts consecutive cycles one master keeps the bus and
// raises a sticky flag once the count reaches TIMEOUT (0 disables it).
module bus_arb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic state_change,
    input  logic busy,
    output logic timeout_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] hold_cnt;

    // Saturates at LIMIT; with TIMEOUT=0 the limit is 0 so it never counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (state_change) begin
            hold_cnt <= '0;
        end else if (busy && hold_cnt != LIMIT) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (TIMEOUT > 0 && hold_cnt == LIMIT) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (host = master 0, DMAC = master 1) with command mux
// and hold watchdog. Define BUS_ARB_ROUND_ROBIN_EN for round-robin tie-break.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              bus_valid,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              timeout_err,
    output arb_dbg_t          dbg
);

    arb_state_e state;
    arb_state_e next_state;
    arb_state_e tie_winner;
    logic       last_owner;
    logic       state_change;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    assign tie_winner = (last_owner == M_HOST) ? GNT1 : GNT0;
`else
    assign tie_winner = GNT0;
`endif

    assign state_change = (next_state != state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_owner <= M_DMAC;
        end else begin
            state <= next_state;
            if (state_change && next_state == GNT0) begin
                last_owner <= M_HOST;
            end else if (state_change && next_state == GNT1) begin
                last_owner <= M_DMAC;
            end
        end
    end

    // Owners are never preempted; on release the other master takes over
    // at the same edge if it is already requesting.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    next_state = tie_winner;
                end else if (m0_req) begin
                    next_state = GNT0;
                end else if (m1_req) begin
                    next_state = GNT1;
                end
            end
            GNT0: begin
                if (!m0_req) begin
                    next_state = m1_req ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    next_state = m0_req ? GNT0 : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign m0_grant = (state == GNT0);
    assign m1_grant = (state == GNT1);

    always_comb begin
        bus_valid = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            GNT0: begin
                bus_valid = 1'b1;
                bus_wr    = m0_wr;
                bus_addr  = m0_addr;
                bus_wdata = m0_dout;
            end
            GNT1: begin
                bus_valid = 1'b1;
                bus_wr    = m1_wr;
                bus_addr  = m1_addr;
                bus_wdata = m1_dout;
            end
            default: ;
        endcase
    end

    assign dbg.state      = state;
    assign dbg.last_owner = last_owner;

    bus_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .reset_n     (reset_n),
        .state_change(state_change),
        .busy        (state != IDLE),
        .timeout_err (timeout_err)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table for arbitration and muxing,
// plus hand sequences for reset, tie-breaking, watchdog and async reset.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              m0_req = 1'b0, m0_wr = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_dout = '0;
    logic              m1_req = 1'b0, m1_wr = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_dout = '0;
    logic              m0_grant, m1_grant, bus_valid, bus_wr, timeout_err;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    arb_dbg_t          dbg;

    bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_addr    (m0_addr),
        .m0_dout    (m0_dout),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_addr    (m1_addr),
        .m1_dout    (m1_dout),
        .m0_grant   (m0_grant),
        .m1_grant   (m1_grant),
        .bus_valid  (bus_valid),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .timeout_err(timeout_err),
        .dbg        (dbg)
    );

    typedef struct {
        logic              m0_req;
        logic              m0_wr;
        logic [ADDR_W-1:0] m0_addr;
        logic [DATA_W-1:0] m0_dout;
        logic              m1_req;
        logic              m1_wr;
        logic [ADDR_W-1:0] m1_addr;
        logic [DATA_W-1:0] m1_dout;
        logic              g0;
        logic              g1;
        logic              valid;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_dout = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_dout = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_bus(input string tag, input logic g0, input logic g1, input logic valid,
                             input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        check({tag, " m0_grant"}, 32'(m0_grant), 32'(g0));
        check({tag, " m1_grant"}, 32'(m1_grant), 32'(g1));
        check({tag, " bus_valid"}, 32'(bus_valid), 32'(valid));
        check({tag, " bus_wr"}, 32'(bus_wr), 32'(wr));
        check({tag, " bus_addr"}, 32'(bus_addr), 32'(addr));
        check({tag, " bus_wdata"}, bus_wdata, wdata);
    endtask

    vec_t vecs[9];
    logic tie_exp[3];

    initial begin
        // m0 fields | m1 fields | expected grants, valid, wr, addr, wdata
        vecs[0] = '{0, 0, 16'h0000, 32'h0, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 0, 16'h0000, 32'h0};
        vecs[1] = '{0, 0, 16'h0000, 32'h0, 1, 1, 16'h0040, 32'hDEADBEEF, 0, 1, 1, 1, 16'h0040, 32'hDEADBEEF};
        vecs[2] = '{1, 1, 16'h0100, 32'hCAFEF00D, 1, 0, 16'h0044, 32'h12345678, 0, 1, 1, 0, 16'h0044, 32'h12345678};
        vecs[3] = '{1, 1, 16'h0100, 32'hCAFEF00D, 0, 0, 16'h0000, 32'h0, 1, 0, 1, 1, 16'h0100, 32'hCAFEF00D};
        vecs[4] = '{1, 0, 16'h0104, 32'h0BADF00D, 1, 1, 16'h0200, 32'hA5A5A5A5, 1, 0, 1, 0, 16'h0104, 32'h0BADF00D};
        vecs[5] = '{0, 0, 16'h0000, 32'h0, 1, 1, 16'h0200, 32'hA5A5A5A5, 0, 1, 1, 1, 16'h0200, 32'hA5A5A5A5};
        vecs[6] = '{0, 0, 16'h0000, 32'h0, 0, 1, 16'h0300, 32'h11111111, 0, 0, 0, 0, 16'h0000, 32'h0};
        vecs[7] = '{1, 0, 16'hFFFF, 32'hFFFFFFFF, 0, 1, 16'h0300, 32'h22222222, 1, 0, 1, 0, 16'hFFFF, 32'hFFFFFFFF};
        vecs[8] = '{0, 1, 16'h1234, 32'h33333333, 0, 1, 16'h4321, 32'h44444444, 0, 0, 0, 0, 16'h0000, 32'h0};

`ifdef BUS_ARB_ROUND_ROBIN_EN
        tie_exp = '{1'b0, 1'b1, 1'b0};
`else
        tie_exp = '{1'b0, 1'b0, 1'b0};
`endif

        // Reset held with both masters requesting, then released.
        reset_n = 1'b0;
        drive_idle();
        m0_req = 1'b1;
        m1_req = 1'b1;
        step();
        check_bus("reset", 0, 0, 0, 0, '0, '0);
        check("reset timeout_err", 32'(timeout_err), 32'd0);
        check("reset state", 32'(dbg.state), 32'(IDLE));
        check("reset last_owner", 32'(dbg.last_owner), 32'(M_DMAC));
        reset_n = 1'b1;
        step();
        check("post-reset m0_grant", 32'(m0_grant), 32'd1);
        check("post-reset m1_grant", 32'(m1_grant), 32'd0);

        // Vector table: arbitration, no preemption, handover, mux.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            m0_req = vecs[i].m0_req; m0_wr = vecs[i].m0_wr;
            m0_addr = vecs[i].m0_addr; m0_dout = vecs[i].m0_dout;
            m1_req = vecs[i].m1_req; m1_wr = vecs[i].m1_wr;
            m1_addr = vecs[i].m1_addr; m1_dout = vecs[i].m1_dout;
            step();
            check_bus($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].valid,
                      vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d timeout_err", i), 32'(timeout_err), 32'd0);
        end

        // Three simultaneous requests from IDLE.
        do_reset();
        for (int t = 0; t < 3; t++) begin
            m0_req = 1'b1;
            m1_req = 1'b1;
            step();
            check($sformatf("tie%0d m0_grant", t), 32'(m0_grant), 32'(!tie_exp[t]));
            check($sformatf("tie%0d m1_grant", t), 32'(m1_grant), 32'(tie_exp[t]));
            m0_req = 1'b0;
            m1_req = 1'b0;
            step();
            check($sformatf("tie%0d idle valid", t), 32'(bus_valid), 32'd0);
        end

        // Watchdog: entry edge is n=0; flag sets at the edge ending grant cycle 9.
        do_reset();
        for (int n = 0; n < 12; n++) begin
            m0_req = 1'b1;
            step();
            check($sformatf("wd%0d m0_grant", n), 32'(m0_grant), 32'd1);
            check($sformatf("wd%0d timeout_err", n), 32'(timeout_err), 32'(n >= 9));
        end
        m0_req = 1'b0;
        step();
        check("wd release m0_grant", 32'(m0_grant), 32'd0);
        for (int n = 0; n < 3; n++) begin
            check($sformatf("wd sticky%0d", n), 32'(timeout_err), 32'd1);
            step();
        end
        reset_n = 1'b0;
        #1;
        check("wd cleared by reset", 32'(timeout_err), 32'd0);

        // Asynchronous reset in the middle of a GNT1 cycle.
        do_reset();
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0ABC; m1_dout = 32'h5A5A5A5A;
        step();
        check_bus("pre-async", 0, 1, 1, 1, 16'h0ABC, 32'h5A5A5A5A);
        #2;
        reset_n = 1'b0;
        #1;
        check_bus("async reset", 0, 0, 0, 0, '0, '0);
        #1;
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master bus arbiter for the DMAC subsystem.
- Master 0 is the host (CPU or testbench); master 1 is the DMAC master port (its m_req, m_wr, m_addr, m_dout and m_grant signals).
- Arbitrates bus ownership, muxes the granted master's command onto the shared slave bus, and flags masters that hold the bus too long.
- Sits between the masters and the slave-side address decoder (memory, DMAC slave registers).

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 32, write-data width.
- TIMEOUT, 1024, max consecutive grant cycles before timeout_err is raised; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 bus request.
- m0_wr  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_W  master 0 address.
- m0_dout  in  DATA_W  master 0 write data.
- m1_req  in  1  master 1 (DMAC) bus request.
- m1_wr  in  1  master 1 write/read.
- m1_addr  in  ADDR_W  master 1 address.
- m1_dout  in  DATA_W  master 1 write data.
- m0_grant  out  1  master 0 owns bus (registered).
- m1_grant  out  1  master 1 owns bus (registered).
- bus_valid  out  1  a master owns the bus.
- bus_wr  out  1  muxed write strobe.
- bus_addr  out  ADDR_W  muxed address.
- bus_wdata  out  DATA_W  muxed write data.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; m0_grant=0, m1_grant=0; last_owner=1 (so master 0 wins the first RR tie).
  - hold_cnt=0; timeout_err=0.
  - Bus outputs all 0.
- FSM states: IDLE, GNT0, GNT1. Grants decode directly from state (GNT0 -> m0_grant=1), so they are glitch-free registers.
- IDLE:
  - Only m0_req -> GNT0. Only m1_req -> GNT1.
  - Both requesting -> winner per arbitration policy.
  - Neither -> stay in IDLE.
  - Latency: grant is high the cycle after req is first sampled high.
- GNT0 (GNT1 symmetric):
  - Stay while m0_req=1. No preemption, ever.
  - On m0_req=0: go to GNT1 if m1_req=1 (no idle bubble), else IDLE.
  - last_owner updates on every grant entry.
- Bus mux (combinational from state):
  - GNT0 routes m0_* to bus_*; GNT1 routes m1_*.
  - IDLE drives bus_wr=0, bus_addr=0, bus_wdata=0, bus_valid=0.
- Watchdog:
  - hold_cnt clears on every state change; otherwise increments each cycle in GNT0/GNT1, saturating at TIMEOUT.
  - When hold_cnt reaches TIMEOUT (TIMEOUT>0), timeout_err sets on the next edge.
  - timeout_err is sticky; only reset clears it. Grant is not revoked.
  - hold_cnt width is $clog2(TIMEOUT+1), minimum 1.
- Simultaneous events:
  - Owner drops req in the same cycle the other raises req: handover occurs at the same edge.
  - Req deasserted before grant: the request is forgotten; no grant is issued.
- Reset mid-transfer: grants drop immediately (async); no state is retained.

Optional Feature:
- Macro: BUS_ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request from IDLE, the master that is not last_owner wins.
- Undefined: fixed priority, master 0 always wins ties. last_owner register is still present but unused; synthesis may trim it.
- Handover-on-release behaviour is identical in both builds.

Decomposition:
- Shared package bus_arb_pkg holds:
  - State encoding: IDLE=2'b00, GNT0=2'b01, GNT1=2'b10.
  - Master index constants M_HOST=0, M_DMAC=1.
  - Default ADDR_W / DATA_W.
- One sub-module: bus_arb_watchdog (hold counter + sticky flag), fed by a state-change pulse and a busy signal.
- Mux and FSM stay in the top.

Test Plan:
- Reset with both req=1, then release reset: m0_grant=1 one cycle later; m1_grant=0.
- m1_req=1 alone, m1_addr=16'h0040, m1_wr=1, m1_dout=32'hDEADBEEF: next cycle m1_grant=1, bus_addr=16'h0040, bus_wr=1, bus_wdata=32'hDEADBEEF, bus_valid=1.
- GNT0 with m1_req pending; drop m0_req: next edge m1_grant=1 and m0_grant=0 with no IDLE cycle in between.
- Tie sequence from IDLE, three times:
  - RR build: grants go 0, 1, 0.
  - Fixed build: grants go 0, 0, 0.
- TIMEOUT=8, hold m0_req for 12 cycles: timeout_err=1 after the 9th grant cycle, stays high after the release, clears only on reset_n=0.
- Assert reset_n=0 mid-GNT1: m1_grant and bus_* go to 0 asynchronously, without waiting for a clock edge.
